// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared constants for the 12-bit pipelined ALU and its command sequencer.
package alu_cmd_sequencer_pkg;

    localparam int ALU_W   = 12;
    localparam int ALU_LAT = 3;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_SHR  = 3'b100;
    localparam logic [2:0] OP_INC  = 3'b101;
    localparam logic [2:0] OP_DEC  = 3'b110;
    localparam logic [2:0] OP_ZERO = 3'b111;

    // Width of one queued command: A, B, SEL and TAG packed together.
    function automatic int cmd_width(input int w, input int tag_w);
        return 2 * w + 3 + tag_w;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and result channels of the sequencer; slave is the sequencer side.
interface alu_cmd_sequencer_if #(
    parameter int W     = 12,
    parameter int TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [2:0]       in_sel;
    logic [TAG_W-1:0] in_tag;

    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [2:0]       alu_sel;
    logic [W-1:0]     alu_f;

    logic             res_valid;
    logic [W-1:0]     res_f;
    logic [2:0]       res_sel;
    logic [TAG_W-1:0] res_tag;

    modport master (
        output in_valid, in_a, in_b, in_sel, in_tag, alu_f,
        input  in_ready, alu_a, alu_b, alu_sel,
        input  res_valid, res_f, res_sel, res_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sel, in_tag, alu_f,
        output in_ready, alu_a, alu_b, alu_sel,
        output res_valid, res_f, res_sel, res_tag
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; flush empties it and overrides any same-cycle push/pop.
module alu_cmd_fifo #(
    parameter int  WIDTH = 31,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues one per cycle and tags which cycle's F belongs to which command.
module alu_cmd_sequencer #(
    parameter int  W       = alu_cmd_sequencer_pkg::ALU_W,
    parameter int  DEPTH   = 8,
    parameter int  TAG_W   = 4,
    parameter int  ALU_LAT = alu_cmd_sequencer_pkg::ALU_LAT,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                issue_en,
    alu_cmd_sequencer_if.slave  bus,
    output logic [CW-1:0]       count
);
    import alu_cmd_sequencer_pkg::*;

    localparam int CMD_W = cmd_width(W, TAG_W);

    logic [CMD_W-1:0] wdata, rdata;
    logic             full, empty, pop;
    logic [W-1:0]     hd_a, hd_b;
    logic [2:0]       hd_sel;
    logic [TAG_W-1:0] hd_tag;

    // Stage 0 is the issue register itself; stage ALU_LAT lines up with alu_f.
    logic [ALU_LAT:0]            vld_pipe;
    logic [ALU_LAT:0][2:0]       sel_pipe;
    logic [ALU_LAT:0][TAG_W-1:0] tag_pipe;

    assign wdata = {bus.in_a, bus.in_b, bus.in_sel, bus.in_tag};
    assign {hd_a, hd_b, hd_sel, hd_tag} = rdata;
    assign pop          = !empty && issue_en && !flush;
    assign bus.in_ready = !full;

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.in_valid),
        .pop   (pop),
        .flush (flush),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_a   <= '0;
            bus.alu_b   <= '0;
            bus.alu_sel <= OP_ZERO;
            vld_pipe    <= '0;
            sel_pipe    <= '0;
            tag_pipe    <= '0;
        end else begin
            if (pop) begin
                bus.alu_a   <= hd_a;
                bus.alu_b   <= hd_b;
                bus.alu_sel <= hd_sel;
                vld_pipe[0] <= 1'b1;
                sel_pipe[0] <= hd_sel;
                tag_pipe[0] <= hd_tag;
            end else begin
                bus.alu_a   <= '0;
                bus.alu_b   <= '0;
                bus.alu_sel <= OP_ZERO;
                vld_pipe[0] <= 1'b0;
                sel_pipe[0] <= '0;
                tag_pipe[0] <= '0;
            end
            // Flush kills commands already inside the ALU by dropping their valid bits.
            for (int i = 1; i <= ALU_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1] && !flush;
                sel_pipe[i] <= sel_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign bus.res_valid = vld_pipe[ALU_LAT];
    assign bus.res_sel   = sel_pipe[ALU_LAT];
    assign bus.res_tag   = tag_pipe[ALU_LAT];
    assign bus.res_f     = bus.alu_f;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench: sequencer driving a behavioural 3-edge ALU, results checked in issue order.
module tb_alu_cmd_sequencer;
    import alu_cmd_sequencer_pkg::*;

    localparam int DEPTH = 8;

    typedef struct {
        logic [11:0] f;
        logic [2:0]  sel;
        logic [3:0]  tag;
        int          acc_cyc;
        bit          exact;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       issue_en;
    logic [3:0] count;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   m_occ = 0;
    exp_t sb[$];
    exp_t pend;

    alu_cmd_sequencer_if #(.W(12), .TAG_W(4)) bus ();

    alu_cmd_sequencer #(.W(12), .DEPTH(DEPTH), .TAG_W(4), .ALU_LAT(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .issue_en (issue_en),
        .bus      (bus),
        .count    (count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] ref_f(input logic [11:0] a, input logic [11:0] b,
                                          input logic [2:0] s);
        logic [23:0] p;
        p = 24'(a) * 24'(b);
        case (s)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return p[11:0];
            OP_SHL:  return a << 1;
            OP_SHR:  return a >> 1;
            OP_INC:  return a + 12'd1;
            OP_DEC:  return a - 12'd1;
            default: return 12'd0;
        endcase
    endfunction

    // Behavioural ALU: result of inputs sampled at edge n appears after edge n+2.
    logic [11:0] f0, f1, f2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f0 <= '0; f1 <= '0; f2 <= '0;
        end else begin
            f0 <= ref_f(bus.alu_a, bus.alu_b, bus.alu_sel);
            f1 <= f0;
            f2 <= f1;
        end
    end
    assign bus.alu_f = f2;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.res_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got f=%0h tag=%0h expected no result (cycle %0d)",
                         bus.res_f, bus.res_tag, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_f",   int'(bus.res_f),   int'(e.f));
                check("res_tag", int'(bus.res_tag), int'(e.tag));
                check("res_sel", int'(bus.res_sel), int'(e.sel));
                if (e.exact) check("latency", cyc - e.acc_cyc, 4);
            end
        end
    end

    task automatic set_cmd(input logic [11:0] a, input logic [11:0] b, input logic [2:0] s,
                           input logic [3:0] t, input logic [11:0] f, input bit ex);
        bus.in_a    = a;
        bus.in_b    = b;
        bus.in_sel  = s;
        bus.in_tag  = t;
        pend.f      = f;
        pend.sel    = s;
        pend.tag    = t;
        pend.exact  = ex;
    endtask

    task automatic rand_cmd(input logic [3:0] t);
        logic [11:0] a, b;
        logic [2:0]  s;
        a = 12'($urandom);
        b = 12'($urandom);
        s = 3'($urandom);
        set_cmd(a, b, s, t, ref_f(a, b, s), 1'b0);
    endtask

    // One clock: occupancy model predicts accept/issue, DUT count and in_ready checked against it.
    task automatic tick(output bit acc);
        bit pop_m;
        check("count",    int'(count),        m_occ);
        check("in_ready", int'(bus.in_ready), int'(m_occ != DEPTH));
        acc   = bus.in_valid && (m_occ != DEPTH) && !flush;
        pop_m = (m_occ > 0) && issue_en && !flush;
        @(posedge clk);
        #1;
        if (flush) begin
            sb.delete();
            m_occ = 0;
        end else begin
            m_occ = m_occ + int'(acc) - int'(pop_m);
            if (acc) begin
                pend.acc_cyc = cyc;
                sb.push_back(pend);
            end
        end
    endtask

    task automatic drain(input int max);
        bit acc;
        int n;
        bus.in_valid = 1'b0;
        issue_en     = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < max) begin
            tick(acc);
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d results outstanding expected 0", sb.size());
            sb.delete();
        end
        repeat (4) tick(acc);
    endtask

    task automatic check_reset_outputs();
        check("rst_count",     int'(count),         0);
        check("rst_in_ready",  int'(bus.in_ready),  1);
        check("rst_alu_a",     int'(bus.alu_a),     0);
        check("rst_alu_b",     int'(bus.alu_b),     0);
        check("rst_alu_sel",   int'(bus.alu_sel),   7);
        check("rst_res_valid", int'(bus.res_valid), 0);
        check("rst_res_sel",   int'(bus.res_sel),   0);
        check("rst_res_tag",   int'(bus.res_tag),   0);
    endtask

    logic [11:0] t2_f [8];

    initial begin
        bit acc;
        int idx;
        rst_n        = 1'b0;
        flush        = 1'b0;
        issue_en     = 1'b1;
        bus.in_valid = 1'b0;
        set_cmd('0, '0, '0, '0, '0, 1'b0);
        #12;
        check_reset_outputs();
        #10 rst_n = 1'b1;
        repeat (3) tick(acc);

        // Single ADD into an idle block
        set_cmd(12'd5, 12'd3, OP_ADD, 4'd1, 12'h008, 1'b1);
        bus.in_valid = 1'b1;
        tick(acc);
        drain(20);

        // All eight opcodes back to back on A=801, B=2
        t2_f = '{12'h803, 12'h7FF, 12'h002, 12'h002, 12'h400, 12'h802, 12'h800, 12'h000};
        for (int i = 0; i < 8; i++) begin
            set_cmd(12'h801, 12'd2, 3'(i), 4'(i), t2_f[i], 1'b1);
            bus.in_valid = 1'b1;
            tick(acc);
        end
        drain(30);

        // Stall issue, overfill by one
        issue_en     = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_cmd(4'(i));
            tick(acc);
        end
        check("full_in_ready", int'(bus.in_ready), 0);
        check("full_count",    int'(count),        8);
        rand_cmd(4'd8);
        tick(acc);
        check("held_count", int'(count), 8);
        issue_en = 1'b1;
        tick(acc);
        check("unstall_count",    int'(count),        7);
        check("unstall_in_ready", int'(bus.in_ready), 1);
        tick(acc);
        check("push_pop_count", int'(count), 7);
        drain(40);

        // Flush one cycle after the third issue; nothing may come back
        for (int i = 0; i < 3; i++) begin
            rand_cmd(4'(i + 9));
            bus.in_valid = 1'b1;
            tick(acc);
        end
        bus.in_valid = 1'b0;
        tick(acc);
        rand_cmd(4'd15);
        bus.in_valid = 1'b1;
        flush        = 1'b1;
        tick(acc);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_alu_sel",   int'(bus.alu_sel),   7);
        check("flush_count",     int'(count),         0);
        check("flush_res_valid", int'(bus.res_valid), 0);
        repeat (8) tick(acc);

        // Asynchronous reset with 5 queued and 2 in flight
        issue_en     = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rand_cmd(4'(i));
            tick(acc);
        end
        bus.in_valid = 1'b0;
        issue_en     = 1'b1;
        tick(acc);
        tick(acc);
        check("pre_reset_count", int'(count), 5);
        issue_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        sb.delete();
        m_occ = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        issue_en = 1'b1;
        set_cmd(12'h123, 12'h045, OP_SUB, 4'd6, 12'h0DE, 1'b1);
        bus.in_valid = 1'b1;
        tick(acc);
        drain(20);

        // 40 random commands under random stalls, wrapping the FIFO pointers
        idx = 0;
        for (int c = 0; c < 1500 && idx < 40; c++) begin
            rand_cmd(4'(idx));
            bus.in_valid = ($urandom_range(3) != 0);
            issue_en     = ($urandom_range(2) != 0);
            tick(acc);
            if (acc) idx++;
        end
        check("random_accepted", idx, 40);
        drain(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
